// File: rtl/serial_bit_source.sv
// Parallel-to-serial bit source feeding the 1010 sequence detector.
// A holding register backs a shift register so back-to-back words stream with no idle bit.
module serial_bit_source #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int MSB_FIRST    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             last_bit,
    output logic             busy
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKS_PER_BIT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r, state_s;
    logic [WIDTH-1:0] hold_r, hold_s;
    logic             hold_full_r, hold_full_s;
    logic [WIDTH-1:0] shift_r, shift_s;
    logic [BW-1:0]    bit_cnt_r, bit_cnt_s;
    logic [DW-1:0]    div_cnt_r, div_cnt_s;
    logic             load_s;
    logic             accept_s;
    logic             x_r, x_s;
    logic             x_valid_r, x_valid_s;
    logic             last_bit_r, last_bit_s;
    logic             busy_r, busy_s;
    logic             din_ready_r, din_ready_s;

    function automatic logic head_bit(input logic [WIDTH-1:0] sr);
        if (MSB_FIRST != 0) begin
            return sr[WIDTH-1];
        end else begin
            return sr[0];
        end
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] sr);
        if (MSB_FIRST != 0) begin
            return {sr[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, sr[WIDTH-1:1]};
        end
    endfunction

    assign din_ready = din_ready_r;
    assign x         = x_r;
    assign x_valid   = x_valid_r;
    assign last_bit  = last_bit_r;
    assign busy      = busy_r;

    // Next-state logic; outputs are derived from the next state so they register cleanly.
    always_comb begin
        state_s     = state_r;
        hold_s      = hold_r;
        hold_full_s = hold_full_r;
        shift_s     = shift_r;
        bit_cnt_s   = bit_cnt_r;
        div_cnt_s   = div_cnt_r;
        load_s      = 1'b0;
        accept_s    = din_valid && din_ready_r;

        case (state_r)
            IDLE: begin
                if (hold_full_r) begin
                    load_s  = 1'b1;
                    state_s = SHIFT;
                end else begin
                    state_s = IDLE;
                end
            end
            SHIFT: begin
                if (div_cnt_r == DIV_LAST) begin
                    div_cnt_s = {DW{1'b0}};
                    if (bit_cnt_r == BIT_LAST) begin
                        if (hold_full_r) begin
                            load_s = 1'b1;
                        end else begin
                            state_s   = IDLE;
                            bit_cnt_s = {BW{1'b0}};
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r + BW'(1);
                        shift_s   = advance(shift_r);
                    end
                end else begin
                    div_cnt_s = div_cnt_r + DW'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Ready is low while hold is full, so a load and an accept never share an edge.
        if (load_s) begin
            shift_s     = hold_r;
            bit_cnt_s   = {BW{1'b0}};
            div_cnt_s   = {DW{1'b0}};
            hold_full_s = 1'b0;
        end else if (accept_s) begin
            hold_s      = din;
            hold_full_s = 1'b1;
        end else begin
            hold_full_s = hold_full_r;
        end

        busy_s      = (state_s == SHIFT);
        x_s         = busy_s ? head_bit(shift_s) : 1'b0;
        x_valid_s   = busy_s && (div_cnt_s == {DW{1'b0}});
        last_bit_s  = busy_s && (bit_cnt_s == BIT_LAST);
        din_ready_s = !hold_full_s;
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            hold_r      <= {WIDTH{1'b0}};
            hold_full_r <= 1'b0;
            shift_r     <= {WIDTH{1'b0}};
            bit_cnt_r   <= {BW{1'b0}};
            div_cnt_r   <= {DW{1'b0}};
            x_r         <= 1'b0;
            x_valid_r   <= 1'b0;
            last_bit_r  <= 1'b0;
            busy_r      <= 1'b0;
            din_ready_r <= 1'b1;
        end else begin
            state_r     <= state_s;
            hold_r      <= hold_s;
            hold_full_r <= hold_full_s;
            shift_r     <= shift_s;
            bit_cnt_r   <= bit_cnt_s;
            div_cnt_r   <= div_cnt_s;
            x_r         <= x_s;
            x_valid_r   <= x_valid_s;
            last_bit_r  <= last_bit_s;
            busy_r      <= busy_s;
            din_ready_r <= din_ready_s;
        end
    end

endmodule

// File: tb/tb_serial_bit_source.sv
// Bench for serial_bit_source: two instances (defaults, and 4 clocks/bit LSB-first)
// checked every cycle against a word/time-index reference model plus directed literals.
module tb_serial_bit_source;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] din_a = 8'h00, din_b = 8'h00;
    logic valid_a = 1'b0, valid_b = 1'b0;
    logic ready_a, x_a, xv_a, lb_a, busy_a;
    logic ready_b, x_b, xv_b, lb_b, busy_b;

    serial_bit_source #(.WIDTH(8), .CLKS_PER_BIT(1), .MSB_FIRST(1)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .din_valid(valid_a), .din_ready(ready_a),
        .x(x_a), .x_valid(xv_a), .last_bit(lb_a), .busy(busy_a)
    );

    serial_bit_source #(.WIDTH(8), .CLKS_PER_BIT(4), .MSB_FIRST(0)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .din_valid(valid_b), .din_ready(ready_b),
        .x(x_b), .x_valid(xv_b), .last_bit(lb_b), .busy(busy_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: one word in flight, t = clocks elapsed inside that word.
    typedef struct packed {
        logic       hold_full;
        logic [7:0] hold;
        logic [7:0] word;
        logic       active;
        logic [7:0] t;
    } mstate_t;

    function automatic mstate_t mstep(input mstate_t m, input logic v, input logic [7:0] d,
                                      input int cpb);
        mstate_t n = m;
        logic acc = v && !m.hold_full;
        if (m.active) begin
            if (int'(m.t) == 8 * cpb - 1) begin
                if (m.hold_full) begin
                    n.word = m.hold; n.t = 8'd0; n.hold_full = 1'b0;
                end else begin
                    n.active = 1'b0; n.t = 8'd0;
                end
            end else begin
                n.t = m.t + 8'd1;
            end
        end else if (m.hold_full) begin
            n.word = m.hold; n.active = 1'b1; n.t = 8'd0; n.hold_full = 1'b0;
        end
        if (acc) begin
            n.hold_full = 1'b1; n.hold = d;
        end
        return n;
    endfunction

    // Expected {x, x_valid, last_bit, busy, din_ready}.
    function automatic logic [4:0] mexp(input mstate_t m, input int cpb, input bit msb);
        int k = int'(m.t) / cpb;
        int ph = int'(m.t) % cpb;
        if (m.active) begin
            return {m.word[msb ? 7 - k : k], ph == 0, k == 7, 1'b1, !m.hold_full};
        end else begin
            return {4'b0000, !m.hold_full};
        end
    endfunction

    function automatic logic [31:0] packq(input bit q[$]);
        logic [31:0] v = 32'h0;
        foreach (q[i]) v = {v[30:0], q[i]};
        return v;
    endfunction

    mstate_t ma, mb;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ma <= '0;
            mb <= '0;
        end else begin
            ma <= mstep(ma, valid_a, din_a, 1);
            mb <= mstep(mb, valid_b, din_b, 4);
        end
    end

    always @(negedge clk) begin
        check("outs_a", {27'h0, x_a, xv_a, lb_a, busy_a, ready_a}, {27'h0, mexp(ma, 1, 1'b1)});
        check("outs_b", {27'h0, x_b, xv_b, lb_b, busy_b, ready_b}, {27'h0, mexp(mb, 4, 1'b0)});
    end

    bit qa[$], la[$], qb[$];
    int busy_cnt_b = 0;
    int xhigh_cnt_b = 0;

    always @(negedge clk) begin
        if (xv_a) begin
            qa.push_back(x_a);
            la.push_back(lb_a);
        end
        if (xv_b) qb.push_back(x_b);
        if (busy_b) busy_cnt_b <= busy_cnt_b + 1;
        if (x_b) xhigh_cnt_b <= xhigh_cnt_b + 1;
    end

    task automatic send_a(input logic [7:0] w);
        int n = 0;
        valid_a = 1'b1;
        din_a   = w;
        while (ma.hold_full && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++; bad++;
            $display("FAIL send_a timeout: got busy hold want empty hold");
        end
        @(negedge clk);
    endtask

    task automatic send_b(input logic [7:0] w);
        int n = 0;
        valid_b = 1'b1;
        din_b   = w;
        while (mb.hold_full && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            total++; bad++;
            $display("FAIL send_b timeout: got busy hold want empty hold");
        end
        @(negedge clk);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while ((ma.active || ma.hold_full || mb.active || mb.hold_full) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (n >= limit) begin
            total++; bad++;
            $display("FAIL wait_idle timeout: got still busy want idle");
        end
        @(negedge clk);
    endtask

    initial begin
        int idle_bad;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        check("rst_a", {27'h0, x_a, xv_a, lb_a, busy_a, ready_a}, 32'h1);
        check("rst_b", {27'h0, x_b, xv_b, lb_b, busy_b, ready_b}, 32'h1);

        idle_bad = 0;
        repeat (50) begin
            @(negedge clk);
            if ({x_a, xv_a, busy_a, ready_a} !== 4'b0001) idle_bad++;
        end
        check("idle_50", 32'(idle_bad), 32'h0);

        // Basic word, MSB first, one clock per bit.
        qa.delete(); la.delete();
        send_a(8'hA5);
        valid_a = 1'b0;
        wait_idle(100);
        check("a5_bits", packq(qa), 32'hA5);
        check("a5_count", 32'(qa.size()), 32'd8);
        check("a5_last", packq(la), 32'h01);
        check("a5_after", {30'h0, x_a, busy_a}, 32'h0);

        // Back-to-back words stream without a gap.
        qa.delete(); la.delete();
        send_a(8'h0A);
        send_a(8'hAA);
        check("b2b_ready_low", {31'h0, ready_a}, 32'h0);
        valid_a = 1'b0;
        wait_idle(100);
        check("b2b_bits", packq(qa), 32'h0AAA);
        check("b2b_count", 32'(qa.size()), 32'd16);

        // Backpressure: valid held high over three queued words.
        qa.delete(); la.delete();
        send_a(8'h3C);
        send_a(8'hC3);
        send_a(8'h96);
        valid_a = 1'b0;
        wait_idle(100);
        check("bp_bits", packq(qa), 32'h3CC396);
        check("bp_count", 32'(qa.size()), 32'd24);

        // Four clocks per bit, LSB first.
        qb.delete();
        busy_cnt_b  = 0;
        xhigh_cnt_b = 0;
        send_b(8'h01);
        valid_b = 1'b0;
        wait_idle(200);
        check("b01_bits", packq(qb), 32'h80);
        check("b01_count", 32'(qb.size()), 32'd8);
        check("b01_busy", 32'(busy_cnt_b), 32'd32);
        check("b01_xhigh", 32'(xhigh_cnt_b), 32'd4);

        // Asynchronous reset mid-word with the holding register full.
        send_a(8'hFF);
        send_a(8'h55);
        check("mid_hold_full", {31'h0, ready_a}, 32'h0);
        @(negedge clk);
        valid_a = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("async_rst", {27'h0, x_a, xv_a, lb_a, busy_a, ready_a}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        qa.delete(); la.delete();
        repeat (20) @(negedge clk);
        check("post_rst_bits", 32'(qa.size()), 32'd0);
        check("post_rst_busy", {31'h0, busy_a}, 32'h0);

        // Randomized traffic on both instances.
        repeat (3000) begin
            @(negedge clk);
            valid_a = ($urandom_range(0, 2) != 0);
            din_a   = 8'($urandom);
            valid_b = ($urandom_range(0, 3) == 0);
            din_b   = 8'($urandom);
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
        wait_idle(400);
        check("final_idle", {28'h0, busy_a, busy_b, ready_a, ready_b}, 32'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
